// File: rtl/pport_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pport_pkg
// Brief    : Shared types and widths for the uio byte transmitter.
// Revision : 1.0
// ============================================================================
package pport_pkg;

    localparam int DATA_W = 8;
    localparam int TO_W   = 8;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SETUP    = 3'd1,
        STROBE   = 3'd2,
        WAIT_ACK = 3'd3,
        WAIT_REL = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/pport_fifo.sv
`default_nettype none
// ============================================================================
// Module   : pport_fifo
// Brief    : Byte FIFO with registered full/empty flags and wrap-bit pointers.
// Revision : 1.0
// ============================================================================
module pport_fifo
    import pport_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              full,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic [AW:0]       level_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              wr_fire, rd_fire;

    // Flags are computed from the next pointers so they are registered,
    // keeping any pop out of the combinational path to full.
    always_comb begin
        wr_fire  = wr_en & ~full_q;
        rd_fire  = rd_en & ~empty_q;
        wr_ptr_d = wr_ptr_q + (AW+1)'(wr_fire);
        rd_ptr_d = rd_ptr_q + (AW+1)'(rd_fire);
        level_d  = wr_ptr_d - rd_ptr_d;
        full_d   = (level_d == FULL_LVL);
        empty_d  = (wr_ptr_d == rd_ptr_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];
    assign full    = full_q;
    assign empty   = empty_q;

endmodule
`default_nettype wire

// File: rtl/pport_tx.sv
`default_nettype none
// ============================================================================
// Module   : pport_tx
// Brief    : FIFO-buffered byte transmitter on uio pins, strobe/ack handshake.
//            Optional PPORT_TX_PARITY_EN adds the pin_parity output.
// Revision : 1.0
// ============================================================================
module pport_tx
    import pport_pkg::*;
#(
    parameter int DEPTH         = 4,
    parameter int STROBE_CYCLES = 2,
    parameter int ACK_TIMEOUT   = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] pin_data_out,
    output logic [DATA_W-1:0] pin_data_oe,
    output logic              pin_strobe_n,
    input  logic              pin_ack_n,
    output logic              busy,
    output logic              timeout_err,
    input  logic              err_clr
`ifdef PPORT_TX_PARITY_EN
    ,
    output logic              pin_parity
`endif
);

    localparam logic [TO_W-1:0] STB_LAST = TO_W'(STROBE_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(ACK_TIMEOUT - 1);

    logic              fifo_full, fifo_empty;
    logic [DATA_W-1:0] fifo_rd_data;
    logic              pop;

    logic              ack_meta_q, ack_s_q;
    state_t            state_q, state_d;
    logic [TO_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              oe_q, oe_d;
    logic              strobe_n_q, strobe_n_d;
    logic              err_q, err_d;
    logic              err_set;

    pport_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (in_valid),
        .wr_data (in_data),
        .full    (fifo_full),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .empty   (fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        oe_d       = oe_q;
        strobe_n_d = strobe_n_q;
        pop        = 1'b0;
        err_set    = 1'b0;
        case (state_q)
            IDLE: begin
                // A host still holding ack low keeps the next byte parked.
                if (!fifo_empty && ack_s_q) begin
                    pop     = 1'b1;
                    data_d  = fifo_rd_data;
                    oe_d    = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                strobe_n_d = 1'b0;
                cnt_d      = '0;
                state_d    = STROBE;
            end
            STROBE: begin
                if (cnt_q == STB_LAST) begin
                    strobe_n_d = 1'b1;
                    cnt_d      = '0;
                    state_d    = WAIT_ACK;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            WAIT_ACK: begin
                if (!ack_s_q) begin
                    state_d = WAIT_REL;
                end else if (cnt_q == TO_LAST) begin
                    err_set = 1'b1;
                    oe_d    = 1'b0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            WAIT_REL: begin
                if (ack_s_q) begin
                    oe_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                oe_d       = 1'b0;
                strobe_n_d = 1'b1;
                state_d    = IDLE;
            end
        endcase
        err_d = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_meta_q <= 1'b1;
            ack_s_q    <= 1'b1;
            state_q    <= IDLE;
            cnt_q      <= '0;
            data_q     <= '0;
            oe_q       <= 1'b0;
            strobe_n_q <= 1'b1;
            err_q      <= 1'b0;
        end else begin
            ack_meta_q <= pin_ack_n;
            ack_s_q    <= ack_meta_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            oe_q       <= oe_d;
            strobe_n_q <= strobe_n_d;
            err_q      <= err_d;
        end
    end

`ifdef PPORT_TX_PARITY_EN
    logic parity_q, parity_d;

    always_comb begin
        parity_d = pop ? ^fifo_rd_data : parity_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end

    assign pin_parity = parity_q;
`endif

    assign in_ready     = ~fifo_full;
    assign pin_data_out = data_q;
    assign pin_data_oe  = {DATA_W{oe_q}};
    assign pin_strobe_n = strobe_n_q;
    assign busy         = (state_q != IDLE) | ~fifo_empty;
    assign timeout_err  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_pport_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_pport_tx
// Brief    : Scoreboard bench for pport_tx with a background host responder.
// Revision : 1.0
// ============================================================================
module tb_pport_tx;

    localparam int DEPTH = 4;
    localparam int STB   = 2;
    localparam int TO    = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] pin_data_out;
    logic [7:0] pin_data_oe;
    logic       pin_strobe_n;
    logic       pin_ack_n;
    logic       busy;
    logic       timeout_err;
    logic       err_clr;
`ifdef PPORT_TX_PARITY_EN
    logic       pin_parity;
`endif

    int         vectors     = 0;
    int         miscompares = 0;
    logic [7:0] exp_q [$];
    bit         host_en     = 1'b0;

    always #5 clk = ~clk;

    pport_tx #(
        .DEPTH         (DEPTH),
        .STROBE_CYCLES (STB),
        .ACK_TIMEOUT   (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .pin_data_out (pin_data_out),
        .pin_data_oe  (pin_data_oe),
        .pin_strobe_n (pin_strobe_n),
        .pin_ack_n    (pin_ack_n),
        .busy         (busy),
        .timeout_err  (timeout_err),
        .err_clr      (err_clr)
`ifdef PPORT_TX_PARITY_EN
        ,
        .pin_parity   (pin_parity)
`endif
    );

    // Scoreboard: every falling strobe must carry the oldest accepted byte.
    initial begin
        logic       prev;
        logic [7:0] e;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (prev && !pin_strobe_n) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL strobe_data: byte %h strobed, nothing expected", pin_data_out);
                end else begin
                    e = exp_q.pop_front();
                    if (pin_data_out !== e) begin
                        miscompares++;
                        $display("FAIL strobe_data: got %h expected %h", pin_data_out, e);
                    end
                end
                vectors++;
                if (pin_data_oe !== 8'hFF) begin
                    miscompares++;
                    $display("FAIL strobe_oe: got %h expected ff", pin_data_oe);
                end
            end
            prev = pin_strobe_n;
        end
    end

    // Host: ack 2 cycles after strobe rises, release 2 cycles later.
    initial begin
        logic prev_h;
        prev_h = 1'b1;
        forever begin
            @(negedge clk);
            if (host_en && !prev_h && pin_strobe_n) begin
                repeat (2) @(negedge clk);
                pin_ack_n = 1'b0;
                repeat (2) @(negedge clk);
                pin_ack_n = 1'b1;
            end
            prev_h = pin_strobe_n;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic push(input logic [7:0] d, output bit acc);
        @(negedge clk);
        in_data  = d;
        in_valid = 1'b1;
        acc      = in_ready;
        if (acc) exp_q.push_back(d);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            if (!busy) done = 1'b1;
        end
        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL wait_idle: busy still %b after %0d cycles, expected 0", busy, budget);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        err_clr   = 1'b0;
        pin_ack_n = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({in_ready, pin_data_out, pin_data_oe, pin_strobe_n, busy, timeout_err} !==
            {1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_vals: rdy=%b out=%h oe=%h stb=%b busy=%b err=%b expected 1 00 00 1 0 0",
                     in_ready, pin_data_out, pin_data_oe, pin_strobe_n, busy, timeout_err);
        end
    endtask

    task automatic test_single();
        bit         acc;
        logic [4:0] stb_seen;
        logic [4:0] stb_exp;
        host_en = 1'b1;
        push(8'hA5, acc);
        vectors++;
        if (!acc) begin
            miscompares++;
            $display("FAIL single_accept: in_ready 0, expected 1");
        end
        stb_exp = 5'b10011;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            stb_seen[i] = pin_strobe_n;
            if (i == 1) begin
                vectors++;
                if (pin_data_oe !== 8'hFF || pin_data_out !== 8'hA5) begin
                    miscompares++;
                    $display("FAIL single_setup: oe=%h out=%h expected ff a5", pin_data_oe, pin_data_out);
                end
            end
        end
        vectors++;
        if (stb_seen !== stb_exp) begin
            miscompares++;
            $display("FAIL single_strobe: pattern %b expected %b", stb_seen, stb_exp);
        end
        wait_idle(40);
        vectors++;
        if (pin_data_oe !== 8'h00 || busy !== 1'b0 || pin_data_out !== 8'hA5) begin
            miscompares++;
            $display("FAIL single_end: oe=%h busy=%b out=%h expected 00 0 a5", pin_data_oe, busy, pin_data_out);
        end
    endtask

    task automatic test_fill();
        bit acc;
        host_en = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            push(8'(i), acc);
            vectors++;
            if (!acc) begin
                miscompares++;
                $display("FAIL fill_accept: byte %0d refused, expected accepted", i);
            end
        end
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL fill_full: in_ready=%b expected 0", in_ready);
        end
        wait_idle(200);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL fill_drain: %0d bytes never strobed, expected 0", exp_q.size());
        end
    endtask

    task automatic test_timeout();
        bit acc;
        bit seen_low;
        bit found;
        host_en  = 1'b0;
        push(8'h11, acc);
        push(8'h22, acc);
        seen_low = 1'b0;
        found    = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (!pin_strobe_n) seen_low = 1'b1;
            else if (seen_low) found = 1'b1;
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL to_strobe: no strobe pulse seen, expected one");
        end
        repeat (9) @(negedge clk);
        vectors++;
        if (timeout_err !== 1'b0) begin
            miscompares++;
            $display("FAIL to_early: err=%b at cycle 9, expected 0", timeout_err);
        end
        @(negedge clk);
        vectors++;
        if (timeout_err !== 1'b1 || pin_data_oe !== 8'h00) begin
            miscompares++;
            $display("FAIL to_set: err=%b oe=%h at cycle 10, expected 1 00", timeout_err, pin_data_oe);
        end
        host_en = 1'b1;
        wait_idle(60);
        vectors++;
        if (exp_q.size() != 0 || timeout_err !== 1'b1) begin
            miscompares++;
            $display("FAIL to_next: pending=%0d err=%b expected 0 1", exp_q.size(), timeout_err);
        end
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        vectors++;
        if (timeout_err !== 1'b0) begin
            miscompares++;
            $display("FAIL to_clear: err=%b expected 0", timeout_err);
        end
    endtask

    task automatic test_hold_ack();
        bit         acc;
        logic [3:0] stb_seen;
        host_en = 1'b0;
        @(negedge clk);
        pin_ack_n = 1'b0;
        repeat (3) @(negedge clk);
        push(8'h33, acc);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            vectors++;
            if (pin_strobe_n !== 1'b1 || pin_data_oe !== 8'h00 || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL hold_block: stb=%b oe=%h busy=%b expected 1 00 1",
                         pin_strobe_n, pin_data_oe, busy);
            end
        end
        pin_ack_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            stb_seen[i] = pin_strobe_n;
        end
        vectors++;
        if (stb_seen !== 4'b0111) begin
            miscompares++;
            $display("FAIL hold_release: strobe pattern %b expected 0111", stb_seen);
        end
        host_en = 1'b1;
        wait_idle(60);
    endtask

`ifdef PPORT_TX_PARITY_EN
    task automatic test_parity();
        bit         acc;
        logic [7:0] bytes [2];
        logic       par   [2];
        bytes[0] = 8'h07; par[0] = 1'b1;
        bytes[1] = 8'h03; par[1] = 1'b0;
        host_en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            push(bytes[i], acc);
            repeat (2) @(negedge clk);
            vectors++;
            if (pin_parity !== par[i] || pin_data_oe !== 8'hFF) begin
                miscompares++;
                $display("FAIL parity: byte %h par=%b oe=%h expected %b ff",
                         bytes[i], pin_parity, pin_data_oe, par[i]);
            end
            wait_idle(60);
        end
    endtask
`endif

    task automatic test_reset_mid();
        bit         found;
        bit         acc;
        logic [7:0] k;
        host_en = 1'b0;
        found   = 1'b0;
        k       = 8'h80;
        for (int i = 0; i < 80 && !found; i++) begin
            @(negedge clk);
            if (!pin_strobe_n && !in_ready) begin
                found = 1'b1;
            end else begin
                in_data  = k;
                in_valid = 1'b1;
                if (in_ready) begin
                    exp_q.push_back(k);
                    k = k + 8'd1;
                end
            end
        end
        in_valid = 1'b0;
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL rmid_setup: never reached full FIFO during strobe");
        end
        #1 rst = 1'b1;
        #1;
        vectors++;
        if ({pin_strobe_n, pin_data_oe, in_ready, busy, timeout_err} !== {1'b1, 8'h00, 1'b1, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL rmid_async: stb=%b oe=%h rdy=%b busy=%b err=%b expected 1 00 1 0 0",
                     pin_strobe_n, pin_data_oe, in_ready, busy, timeout_err);
        end
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        rst     = 1'b0;
        host_en = 1'b1;
        push(8'h5A, acc);
        wait_idle(60);
        vectors++;
        if (exp_q.size() != 0 || pin_data_out !== 8'h5A) begin
            miscompares++;
            $display("FAIL rmid_after: pending=%0d out=%h expected 0 5a", exp_q.size(), pin_data_out);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_timeout();
        test_hold_ack();
`ifdef PPORT_TX_PARITY_EN
        test_parity();
`endif
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
